// File: rtl/poly_add_noise.sv
// poly_add_noise: c = (z + e) mod Q per coefficient, where z is unsigned in [0,Q) and e is small signed noise.
// Latency: a beat accepted in cycle t shows c_vld in cycle t+2. Sustained rate is 1 beat per cycle.
// Backpressure: at most 2 beats are held while c_rdy is low. z_rdy and e_rdy then drop together.
module poly_add_noise #(
    parameter int            N  = 16,
    parameter int            QW = 64,
    parameter int            EW = 8,
    parameter logic [QW-1:0] Q  = 64'hFFFF_FFFF_0000_0001
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic [QW-1:0] z_data,
    input  logic          z_vld,
    input  logic          z_last,
    output logic          z_rdy,
    input  logic [EW-1:0] e_data,
    input  logic          e_vld,
    input  logic          e_last,
    output logic          e_rdy,
    output logic [QW-1:0] c_data,
    output logic          c_vld,
    output logic          c_last,
    input  logic          c_rdy,
    output logic          frame_err
);

    localparam int IW = $clog2(N);

    // Stage-1 register: the product coefficient, the noise already lifted into [0,Q),
    // and the frame-end marker derived from the beat counter.
    typedef struct packed {
        logic          last;
        logic [QW-1:0] z;
        logic [QW:0]   e_mod;
    } s1_t;

    s1_t           s1_q;
    logic          s1_vld;
    logic          s1_rdy;
    logic          s2_rdy;
    logic          fire;
    logic [IW-1:0] idx;
    logic          last_beat;

    logic [QW:0]   q_ext;
    logic [QW:0]   e_ext;
    logic [QW:0]   e_mod;
    logic [QW:0]   sum;
    logic [QW:0]   diff;
    logic [QW-1:0] red;

    // Each stage accepts when it is empty or the stage below is accepting.
    assign s2_rdy = !c_vld | c_rdy;
    assign s1_rdy = !s1_vld | s2_rdy;

    // Join: a beat is consumed only when both streams offer one. Ready is held
    // low during reset so nothing upstream believes a beat was taken.
    assign z_rdy = s_rst_n & e_vld & s1_rdy;
    assign e_rdy = s_rst_n & z_vld & s1_rdy;
    assign fire  = z_vld & e_vld & s1_rdy;

    assign last_beat = (idx == IW'(N - 1));

    // Negative noise is mapped to Q + e. The QW+1 width keeps Q + e and z + e_mod free of overflow.
    assign q_ext = {1'b0, Q};
    assign e_ext = {{(QW + 1 - EW){e_data[EW-1]}}, e_data};
    assign e_mod = e_data[EW-1] ? (q_ext + e_ext) : e_ext;

    // A single conditional subtraction suffices because both operands are below Q.
    // sum < 2Q <= 2^(QW+1), so the top bit of sum - Q is a clean borrow.
    assign sum  = {1'b0, s1_q.z} + s1_q.e_mod;
    assign diff = sum - q_ext;
    assign red  = diff[QW] ? sum[QW-1:0] : diff[QW-1:0];

    // Stage 1: capture the joined beat, advance the beat index, and flag misaligned input 'last' bits.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s1_vld    <= 1'b0;
            s1_q      <= '0;
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            if (s1_rdy) begin
                s1_vld <= fire;
            end
            if (fire) begin
                s1_q.z     <= z_data;
                s1_q.e_mod <= e_mod;
                s1_q.last  <= last_beat;
                idx        <= last_beat ? '0 : idx + IW'(1);
                if ((z_last != last_beat) || (e_last != last_beat)) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // Stage 2: reduce and present on c. Data and last hold while the consumer stalls.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            c_vld  <= 1'b0;
            c_data <= '0;
            c_last <= 1'b0;
        end else if (s2_rdy) begin
            c_vld <= s1_vld;
            if (s1_vld) begin
                c_data <= red;
                c_last <= s1_q.last;
            end
        end
    end

endmodule

// File: tb/tb_poly_add_noise.sv
// tb_poly_add_noise: scoreboard bench for poly_add_noise.
// Expected coefficients are pushed when a joined beat is accepted and popped when c hands one off.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_poly_add_noise;

    localparam int          N = 16;
    localparam logic [63:0] Q = 64'hFFFF_FFFF_0000_0001;

    typedef struct {
        logic [63:0] zd;
        logic        zl;
        logic [7:0]  ed;
        logic        el;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        s_rst_n;
    logic [63:0] z_data;
    logic        z_vld;
    logic        z_last;
    logic        z_rdy;
    logic [7:0]  e_data;
    logic        e_vld;
    logic        e_last;
    logic        e_rdy;
    logic [63:0] c_data;
    logic        c_vld;
    logic        c_last;
    logic        c_rdy;
    logic        frame_err;

    int          n_chk = 0;
    int          n_err = 0;
    beat_t       src[$];
    exp_t        exp_q[$];
    logic        z_acc = 1'b0;
    logic        e_acc = 1'b0;
    int          tb_idx = 0;
    logic        err_model = 1'b0;
    int          cyc = 0;
    int          fire_cnt = 0;
    int          out_cnt = 0;
    int          first_fire = -1;
    int          first_vld = -1;
    int          first_pop = -1;
    int          last_pop = -1;
    logic        hold_pend = 1'b0;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;

    poly_add_noise #(.N(N), .QW(64), .EW(8), .Q(Q)) dut (
        .clk       (clk),
        .s_rst_n   (s_rst_n),
        .z_data    (z_data),
        .z_vld     (z_vld),
        .z_last    (z_last),
        .z_rdy     (z_rdy),
        .e_data    (e_data),
        .e_vld     (e_vld),
        .e_last    (e_last),
        .e_rdy     (e_rdy),
        .c_data    (c_data),
        .c_vld     (c_vld),
        .c_last    (c_last),
        .c_rdy     (c_rdy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference: add the noise as a signed offset. Positive noise adds and wraps past Q.
    // Negative noise subtracts its magnitude and borrows from Q when needed.
    function automatic logic [63:0] ref_add(input logic [63:0] z, input logic [7:0] e);
        int          ev;
        logic [64:0] s;
        logic [63:0] m;
        ev = int'($signed(e));
        if (ev >= 0) begin
            s = {1'b0, z} + 65'(ev);
            if (s >= {1'b0, Q}) s = s - {1'b0, Q};
            return s[63:0];
        end
        m = 64'(-ev);
        if (z >= m) return z - m;
        return (Q - m) + z;
    endfunction

    function automatic logic [63:0] rand_z();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (r >= Q) r = r - Q;
        return r;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            cyc++;
            if (!s_rst_n) begin
                z_acc     = 1'b0;
                e_acc     = 1'b0;
                hold_pend = 1'b0;
            end else begin
                z_acc = z_vld & z_rdy;
                e_acc = e_vld & e_rdy;
                check("frame_err", 64'(frame_err), 64'(err_model));
                if (z_acc | e_acc) check("join", 64'(z_acc), 64'(e_acc));
                if (z_acc & e_acc) begin
                    exp_q.push_back('{data: ref_add(z_data, e_data), last: (tb_idx == N - 1)});
                    if ((z_last != (tb_idx == N - 1)) || (e_last != (tb_idx == N - 1))) err_model = 1'b1;
                    tb_idx = (tb_idx == N - 1) ? 0 : tb_idx + 1;
                    if (first_fire < 0) first_fire = cyc;
                    fire_cnt++;
                end
                if (hold_pend) begin
                    check("stall_vld", 64'(c_vld), 64'd1);
                    check("stall_data", c_data, held_data);
                    check("stall_last", 64'(c_last), 64'(held_last));
                end
                if (c_vld && first_vld < 0) first_vld = cyc;
                if (c_vld && c_rdy) begin
                    check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        x = exp_q.pop_front();
                        check("c_data", c_data, x.data);
                        check("c_last", 64'(c_last), 64'(x.last));
                    end
                    out_cnt++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
                hold_pend = c_vld & !c_rdy;
                held_data = c_data;
                held_last = c_last;
            end
        end
    end

    // Drive every beat in src through the two input streams. Each stream gets its own random gaps.
    // Mode 0 holds c_rdy high. Mode 1 raises c_rdy for one cycle in three.
    task automatic run_stream(input int gap_pct, input int rdy_mode, input int budget);
        int zi = 0;
        int ei = 0;
        int n  = 0;
        int nb;
        nb         = src.size();
        out_cnt    = 0;
        first_fire = -1;
        first_vld  = -1;
        first_pop  = -1;
        last_pop   = -1;
        while ((zi < nb || ei < nb || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (z_acc) zi++;
            if (e_acc) ei++;
            if (!z_vld || z_acc) begin
                if (zi < nb && int'($urandom_range(99)) >= gap_pct) begin
                    z_vld  = 1'b1;
                    z_data = src[zi].zd;
                    z_last = src[zi].zl;
                end else begin
                    z_vld = 1'b0;
                end
            end
            if (!e_vld || e_acc) begin
                if (ei < nb && int'($urandom_range(99)) >= gap_pct) begin
                    e_vld  = 1'b1;
                    e_data = src[ei].ed;
                    e_last = src[ei].el;
                end else begin
                    e_vld = 1'b0;
                end
            end
            c_rdy = (rdy_mode == 0) ? 1'b1 : (n % 3 == 0);
        end
        z_vld = 1'b0;
        e_vld = 1'b0;
        c_rdy = 1'b1;
        check("run_done", 64'(n < budget), 64'd1);
        check("out_count", 64'(out_cnt), 64'(nb));
        src.delete();
    endtask

    initial begin
        int base;
        int k;
        int guard;

        s_rst_n = 1'b0;
        z_vld   = 1'b1;
        e_vld   = 1'b1;
        z_data  = '0;
        e_data  = '0;
        z_last  = 1'b0;
        e_last  = 1'b0;
        c_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_vld", 64'(c_vld), 64'd0);
        check("rst_c_last", 64'(c_last), 64'd0);
        check("rst_c_data", c_data, 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_z_rdy", 64'(z_rdy), 64'd0);
        check("rst_e_rdy", 64'(e_rdy), 64'd0);
        z_vld   = 1'b0;
        e_vld   = 1'b0;
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: z=k, e=+1.
        for (int i = 0; i < N; i++)
            src.push_back('{zd: 64'(i), zl: (i == N - 1), ed: 8'd1, el: (i == N - 1)});
        run_stream(0, 0, 100);
        check("basic_latency", 64'(first_vld - first_fire), 64'd2);
        check("basic_burst", 64'(last_pop - first_pop), 64'd15);

        // Modular wrap corners, padded to a full frame with random coefficients.
        src.push_back('{zd: Q - 64'd1, zl: 1'b0, ed: 8'h01, el: 1'b0});
        src.push_back('{zd: 64'd0,     zl: 1'b0, ed: 8'hFF, el: 1'b0});
        src.push_back('{zd: 64'd5,     zl: 1'b0, ed: 8'hFD, el: 1'b0});
        src.push_back('{zd: Q - 64'd2, zl: 1'b0, ed: 8'h7F, el: 1'b0});
        src.push_back('{zd: 64'd3,     zl: 1'b0, ed: 8'h80, el: 1'b0});
        for (int i = 5; i < N; i++)
            src.push_back('{zd: rand_z(), zl: (i == N - 1), ed: 8'($urandom), el: (i == N - 1)});
        run_stream(0, 0, 100);

        // Misaligned e.last: raised on beat 14 instead of 15, then a clean second frame.
        for (int i = 0; i < 2 * N; i++)
            src.push_back('{zd: 64'(i * 1000), zl: (i % N == N - 1), ed: 8'(i - 16),
                            el: (i == 14) ? 1'b1 : ((i == 15) ? 1'b0 : (i % N == N - 1))});
        run_stream(0, 0, 200);
        check("err_sticky", 64'(frame_err), 64'd1);

        // Reset mid-frame: fire 7 beats, stall the output, confirm the stall limit, then reset.
        base   = fire_cnt;
        k      = 0;
        guard  = 0;
        z_data = 64'd100;
        e_data = 8'd1;
        z_last = 1'b0;
        e_last = 1'b0;
        z_vld  = 1'b1;
        e_vld  = 1'b1;
        c_rdy  = 1'b1;
        while (fire_cnt < base + 7 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
            if (z_acc) begin
                k++;
                z_data = 64'(100 + k);
            end
        end
        c_rdy = 1'b0;
        check("mid_fired", 64'(fire_cnt - base), 64'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_z_rdy", 64'(z_rdy), 64'd0);
            check("stall_e_rdy", 64'(e_rdy), 64'd0);
        end
        check("mid_c_vld", 64'(c_vld), 64'd1);
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_c_vld", 64'(c_vld), 64'd0);
        check("mid_rst_frame_err", 64'(frame_err), 64'd0);
        check("mid_rst_z_rdy", 64'(z_rdy), 64'd0);
        exp_q.delete();
        tb_idx    = 0;
        err_model = 1'b0;
        z_vld     = 1'b0;
        e_vld     = 1'b0;
        c_rdy     = 1'b1;
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            src.push_back('{zd: rand_z(), zl: (i == N - 1), ed: 8'($urandom), el: (i == N - 1)});
        run_stream(0, 0, 100);

        // Back-to-back frames with continuous flow.
        for (int i = 0; i < 2 * N; i++)
            src.push_back('{zd: rand_z(), zl: (i % N == N - 1), ed: 8'($urandom), el: (i % N == N - 1)});
        run_stream(0, 0, 200);
        check("b2b_burst", 64'(last_pop - first_pop), 64'd31);

        // Backpressure: four frames, random input gaps, c_rdy high one cycle in three.
        for (int i = 0; i < 4 * N; i++)
            src.push_back('{zd: rand_z(), zl: (i % N == N - 1), ed: 8'($urandom), el: (i % N == N - 1)});
        run_stream(30, 1, 3000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/poly_add_noise.md
# poly_add_noise

Adds a small signed noise polynomial to a product polynomial, coefficient by coefficient, modulo Q, completing the ct = p·u + e step of FV encryption. It sits directly downstream of the polynomial multiplier. It consumes the multiplier's output stream `z` and a noise stream `e` from the sampler. It emits the reduced sum as stream `c` toward ciphertext packing. Both inputs and the output carry one coefficient per beat over `axis_if` (data, vld, last, rdy).

## Interface
- N, 16, coefficients per polynomial (frame length); ≥ 2
- QW, 64, bit-width of z and c coefficients
- EW, 8, bit-width of the noise coefficient e; two's complement, EW < QW
- Q, 64'hFFFF_FFFF_0000_0001, modulus; 2 < Q < 2^QW
- clk  in  1  single clock, rising edge
- s_rst_n  in  1  reset; asynchronous, active-low
- z  axis_if.in  QW  product coefficients, unsigned, in [0, Q)
- e  axis_if.in  EW  noise coefficients, signed, with |e| < Q
- c  axis_if.out  QW  result coefficients in [0, Q)
- frame_err  out  1  sticky flag: input `last` misaligned with the internal beat count

## Operation
- Join: a beat fires when z.vld & e.vld & s1_rdy.
  - z.rdy = e.vld & s1_rdy; e.rdy = z.vld & s1_rdy.
  - Neither input is consumed alone.
- Stage 1 (on fire): register z.data.
  - Also register e_mod = (e < 0) ? Q + sext(e) : zext(e).
  - Register beat index idx.
- Stage 2: sum = z + e_mod, computed at QW+1 bits.
  - c.data = (sum ≥ Q) ? sum − Q : sum.
  - One conditional subtraction only. Behaviour for z ≥ Q is unspecified.
- Beat counter idx runs 0..N−1. It advances on each fire and wraps N−1 → 0.
  - c.last is generated from idx == N−1 and travels with the data.
  - Input `last` signals are used only for checking.
- frame_err is set when a fired beat has z.last ≠ (idx == N−1) or e.last ≠ (idx == N−1).
  - Once set, it stays high until reset.
  - A misaligned beat is still processed normally.
- Pipeline control: per-stage valid.
  - s2_rdy = !s2_vld | c.rdy; s1_rdy = !s1_vld | s2_rdy.
  - Stage 2 drives c.vld and c.data directly from registers.
- Reset (asserted at any time, including mid-frame):
  - Both stage valids clear, idx → 0, frame_err → 0.
  - Any partial frame is discarded. Upstream blocks must also be reset or restart the frame.

## Timing
- Reset values: c.vld=0, c.last=0, c.data=0, frame_err=0.
  - z.rdy and e.rdy are forced to 0 while s_rst_n is low.
- Latency: a beat fired at edge k appears on c with c.vld=1 after edge k+2. Minimum 2 cycles.
- Throughput: 1 beat/cycle when z.vld, e.vld and c.rdy are held high.
  - N-beat frames run back-to-back with no bubble.
- Handshakes:
  - c.vld never depends combinationally on c.rdy.
  - While c.vld & !c.rdy, c.data and c.last hold stable.
  - z.rdy and e.rdy may depend combinationally on the partner vld and on c.rdy.
- Stall: with c.rdy low, at most 2 beats are buffered. After that, z.rdy and e.rdy drop in the same cycle.
- Simultaneous events:
  - Fire into stage 1 and drain from stage 2 may occur in the same cycle.
  - A counter wrap and frame_err setting on the same beat are both applied.
- Arithmetic:
  - e_mod and sum are computed at QW+1 bits, so there is no overflow for any Q < 2^QW.
  - c.data is always < Q when z < Q.

## Test plan
- Basic frame: N=16, z=k (k=0..15), e=+1, all vld/rdy held high.
  - c = 1..16 in order; c.last only on the 16th beat; first c.vld 2 cycles after the first fire; frame_err=0.
- Modular wrap: (z=Q−1, e=+1), (z=0, e=−1), (z=5, e=−3), (z=Q−2, e=+127), (z=3, e=−128).
  - c = 0, Q−1, 2, 125, Q−125.
- Backpressure and gaps: random vld gaps on z and e independently; c.rdy toggling 1-of-3.
  - All 64 beats (4 frames) arrive exactly once, in order.
  - c.data is stable during every stall.
  - Neither input is accepted without its partner.
- Misaligned last: e.last asserted on beat 14 instead of 15.
  - frame_err rises the cycle after beat 14 fires and stays high.
  - c.last is still on beat 15; the next frame's data is still correct.
- Reset mid-frame: assert s_rst_n low after 7 fired beats with c.rdy=0.
  - c.vld drops immediately and frame_err clears.
  - A subsequent 16-beat frame produces c.last on its 16th beat.
- Back-to-back frames: 32 beats with continuous vld/rdy.
  - 32 outputs in 32 consecutive cycles, c.last on outputs 16 and 32.
